// File: rtl/mux_nto1_rr.sv
// Parametrised N-to-1 registered multiplexer with valid/ready on every channel,
// round-robin or fixed-priority arbitration. Optional macro MUX_FORCE_SEL_EN adds a forced-select bypass.
module mux_nto1_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int RR    = 1,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_FORCE_SEL_EN
  ,
  input  logic               force_en,
  input  logic [SELW-1:0]    force_sel
`endif
);

  logic             load;
  logic             hit;
  logic             bypass;
  logic [N-1:0]     gnt;
  logic [SELW-1:0]  win_idx;
  logic [WIDTH-1:0] win_data;
  logic [SELW-1:0]  ptr;

  // The output register can accept a new item when it is empty or being drained.
  assign load     = !out_valid || out_ready;
  assign in_ready = gnt;

  always_comb begin : arb
    int c;
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    c        = 0;
    gnt      = '0;
    hit      = 1'b0;
    bypass   = 1'b0;
    win_idx  = '0;
    win_data = '0;
`ifdef MUX_FORCE_SEL_EN
    bypass = force_en;
    if (force_en && !rst && load && (int'(force_sel) < N)) begin
      if (in_valid[force_sel]) begin
        hit      = 1'b1;
        win_idx  = force_sel;
        win_data = in_data[int'(force_sel)*WIDTH +: WIDTH];
      end
    end
`endif
    if (!bypass && !rst && load) begin
      // Scan from ptr (round-robin) or from 0 (fixed priority), wrapping at N.
      for (int j = 0; j < N; j++) begin
        c = (RR != 0) ? int'(ptr) + j : j;
        if (c >= N) c = c - N;
        if (!hit && in_valid[c]) begin
          hit      = 1'b1;
          win_idx  = SELW'(c);
          win_data = in_data[c*WIDTH +: WIDTH];
        end
      end
    end
    if (hit) gnt[win_idx] = 1'b1;
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (hit) begin
        out_data  <= win_data;
        out_sel   <= win_idx;
        out_valid <= 1'b1;
        if (RR != 0 && !bypass)
          ptr <= (int'(win_idx) == N - 1) ? '0 : win_idx + SELW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
